fixedpointadder_arbiter: RTL and testbench
==========================================

Name: fixedpointadder_arbiter

Overview:
- Shares one registered fixed-point adder (fixedpointadder, out = a + b, 1-cycle latency) between NREQ requesters in the MVP output-scaling path.
- Round-robin arbitration with per-requester valid/ready handshakes.
- Each result is tagged with its requester id and returned through a 2-entry output FIFO under valid/ready backpressure, sustaining one operation per cycle.

Parameters:
- NREQ, 4, number of requesters (2..16)
- BA, 32, width of operand a (signed)
- BB, 32, width of operand b (signed)
- BOUT, 32, width of sum (signed)
- IDW, $clog2(NREQ), width of requester id

Ports:
- clk  in  1  clock
- clr  in  1  synchronous active-high reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_ready  out  NREQ  grant/accept, one-hot or zero
- req_a  in  NREQ*BA  packed operand a; requester i occupies [i*BA +: BA]
- req_b  in  NREQ*BB  packed operand b; requester i occupies [i*BB +: BB]
- out_valid  out  1  result available at FIFO head
- out_ready  in  1  consumer accepts result
- out_sum  out  BOUT  signed sum at FIFO head
- out_id  out  IDW  requester index of the head result
- busy  out  1  high when any operation is in flight or the FIFO is non-empty

Behaviour:
- Reset (clr=1 at posedge), overriding everything else:
  - FIFO emptied; s1_valid=0; out_valid=0; busy=0.
  - RR pointer = NREQ-1, so requester 0 has top priority first.
  - Adder clr asserted.
  - out_sum/out_id = 0.
  - In-flight operations are discarded, not delivered.
- Arbitration (combinational):
  - Priority order is ptr+1, ptr+2, ... mod NREQ.
  - Winner = first requester with req_valid=1.
  - grant_en = (count - pop + s1_valid) < 2, where count = FIFO occupancy (0..2) and pop = out_valid & out_ready.
  - req_ready[w] = grant_en & winner exists; all other bits 0.
  - A transfer happens when req_valid[i] & req_ready[i].
  - req_ready depends combinationally on out_ready; this path is accepted.
- Issue:
  - On transfer, the adder inputs are the winner's a and b; ptr <= w.
  - With no transfer, adder inputs are 0 and ptr holds.
- Stage 1:
  - s1_valid <= transfer and s1_id <= w, registered.
  - The adder's registered sum aligns with s1_valid.
- FIFO push: when s1_valid=1, {sum, s1_id} is pushed unconditionally. grant_en guarantees space.
- FIFO pop: when out_valid & out_ready, the head advances.
- Simultaneous push and pop: count unchanged. When count=1, the pushed entry becomes the head on the next cycle.
- out_valid = (count != 0). out_sum/out_id show the head entry and stay stable while out_valid & !out_ready.
- Arithmetic:
  - Operands are sign-extended to BOUT before the add.
  - Result wraps modulo 2^BOUT; no saturation, no overflow flag.
- Latency: transfer at cycle N gives out_valid at N+2 (FIFO empty, registered output).
- Throughput: with out_ready held high, one grant per cycle indefinitely.
- Backpressure: with out_ready=0, at most 2 results can be pending (FIFO full, or 1 in FIFO plus 1 in s1). grant_en then drops and req_ready=0.
- busy = s1_valid | (count != 0).
- Requester protocol:
  - Requesters hold req_valid and operands stable until accepted.
  - Dropping req_valid before acceptance is legal; the arbiter simply skips that requester.

Test Plan:
- Reset then single request: req_valid=0001, a=5, b=-7 at cycle 0 -> req_ready=0001 at cycle 0; out_valid at cycle 2 with out_sum=-2, out_id=0; busy=0 after the pop.
- Round-robin fairness: all four requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,... one per cycle; the out_id sequence matches; no gaps after the first result.
- Backpressure: out_ready=0 with all valid -> exactly 2 transfers, then req_ready=0 while out_valid stays 1 with a stable head. Release out_ready -> both results pop in order, then grants resume from the next RR position.
- Wrap-around (BOUT=32): a=32'h7FFFFFFF, b=1 -> out_sum=32'h80000000. Also BA=BB=16, BOUT=32 with a=16'h8000, b=16'h8000 -> out_sum=-65536.
- Reset mid-operation: assert clr for 1 cycle while the FIFO is full and s1_valid=1 -> next cycle out_valid=0, busy=0, and none of the discarded results ever appear. The first grant after reset goes to requester 0 if valid.
- Sparse requests with skipping: only requester 2 valid, ptr=1 -> granted. Requester 3 then becomes valid while 2 is still valid -> 3 is granted before 2's next request.

Source files
------------

// File: rtl/fixedpointadder_arbiter.sv
// Round-robin arbiter sharing one registered fixed-point adder between NREQ requesters.
// Results return tagged with the requester id through a 2-entry output FIFO.

module fixedpointadder #(
    parameter int BA   = 32,
    parameter int BB   = 32,
    parameter int BOUT = 32
) (
    input  logic            i_clk,
    input  logic            i_clr,
    input  logic [BA-1:0]   i_a,
    input  logic [BB-1:0]   i_b,
    output logic [BOUT-1:0] o_sum
);
    logic signed [BOUT-1:0] w_aExt;
    logic signed [BOUT-1:0] w_bExt;

    assign w_aExt = BOUT'($signed(i_a));
    assign w_bExt = BOUT'($signed(i_b));

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            o_sum <= '0;
        end else begin
            o_sum <= w_aExt + w_bExt;
        end
    end
endmodule

module fixedpointadder_arbiter #(
    parameter int NREQ = 4,
    parameter int BA   = 32,
    parameter int BB   = 32,
    parameter int BOUT = 32,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*BA-1:0] req_a,
    input  logic [NREQ*BB-1:0] req_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BOUT-1:0]    out_sum,
    output logic [IDW-1:0]     out_id,
    output logic               busy
);
    logic [IDW-1:0]  r_ptr;
    logic            r_s1Valid;
    logic [IDW-1:0]  r_s1Id;
    logic [1:0]      r_count;
    logic            r_rdPtr;
    logic            r_wrPtr;
    logic [BOUT-1:0] r_memSum [0:1];
    logic [IDW-1:0]  r_memId  [0:1];

    logic            w_found;
    logic [IDW-1:0]  w_winner;
    logic [IDW:0]    w_cand;
    logic            w_pop;
    logic [2:0]      w_occ;
    logic            w_grantEn;
    logic            w_transfer;
    logic [BA-1:0]   w_addA;
    logic [BB-1:0]   w_addB;
    logic [BOUT-1:0] w_sum;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_cand >= (IDW+1)'(NREQ)) begin
                w_cand = w_cand - (IDW+1)'(NREQ);
            end
            if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDW-1:0];
            end
        end
    end

    assign w_pop      = out_valid & out_ready;
    // Results already committed (FIFO plus stage 1) must leave room for this grant.
    assign w_occ      = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_s1Valid};
    assign w_grantEn  = (w_occ < 3'd2);
    assign w_transfer = w_grantEn & w_found;

    always_comb begin
        req_ready = '0;
        if (w_transfer) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    assign w_addA = w_transfer ? req_a[int'(w_winner)*BA +: BA] : '0;
    assign w_addB = w_transfer ? req_b[int'(w_winner)*BB +: BB] : '0;

    fixedpointadder #(
        .BA   (BA),
        .BB   (BB),
        .BOUT (BOUT)
    ) u_adder (
        .i_clk (clk),
        .i_clr (clr),
        .i_a   (w_addA),
        .i_b   (w_addB),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_ptr     <= IDW'(NREQ - 1);
            r_s1Valid <= 1'b0;
            r_s1Id    <= '0;
        end else begin
            r_s1Valid <= w_transfer;
            r_s1Id    <= w_winner;
            if (w_transfer) begin
                r_ptr <= w_winner;
            end
        end
    end

    // Stage-1 results push unconditionally; the grant gate guarantees space.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count     <= '0;
            r_rdPtr     <= 1'b0;
            r_wrPtr     <= 1'b0;
            r_memSum[0] <= '0;
            r_memSum[1] <= '0;
            r_memId[0]  <= '0;
            r_memId[1]  <= '0;
        end else begin
            if (r_s1Valid) begin
                r_memSum[r_wrPtr] <= w_sum;
                r_memId[r_wrPtr]  <= r_s1Id;
                r_wrPtr           <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({r_s1Valid, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = (r_count != 2'd0);
    assign out_sum   = r_memSum[r_rdPtr];
    assign out_id    = r_memId[r_rdPtr];
    assign busy      = r_s1Valid | (r_count != 2'd0);
endmodule

// File: tb/tb_fixedpointadder_arbiter.sv
// Directed and randomized bench for fixedpointadder_arbiter, checked against a queue-based
// model of accepted requests; a second narrow-operand instance covers sign extension.

module tb_fixedpointadder_arbiter;
    localparam int NREQ = 4;
    localparam int BA   = 32;
    localparam int BB   = 32;
    localparam int BOUT = 32;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               clr;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*BA-1:0] req_a;
    logic [NREQ*BB-1:0] req_b;
    logic               out_valid;
    logic               out_ready;
    logic [BOUT-1:0]    out_sum;
    logic [IDW-1:0]     out_id;
    logic               busy;

    logic        clr2;
    logic [1:0]  rv2;
    logic [1:0]  ready2;
    logic [31:0] ra2;
    logic [31:0] rb2;
    logic        ov2;
    logic        or2;
    logic [31:0] sum2;
    logic [0:0]  id2;
    logic        busy2;

    always #5 clk = ~clk;

    fixedpointadder_arbiter #(
        .NREQ (NREQ), .BA (BA), .BB (BB), .BOUT (BOUT), .IDW (IDW)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .busy      (busy)
    );

    fixedpointadder_arbiter #(
        .NREQ (2), .BA (16), .BB (16), .BOUT (32)
    ) dut16 (
        .clk       (clk),
        .clr       (clr2),
        .req_valid (rv2),
        .req_ready (ready2),
        .req_a     (ra2),
        .req_b     (rb2),
        .out_valid (ov2),
        .out_ready (or2),
        .out_sum   (sum2),
        .out_id    (id2),
        .busy      (busy2)
    );

    typedef struct {
        logic [31:0] sum;
        int          id;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          mPtr = NREQ - 1;
    int          now = 0;
    logic [3:0]  hv = '0;
    logic [31:0] ha [NREQ];
    logic [31:0] hb [NREQ];
    logic [3:0]  obsReady;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive requesters, compare against the model, then commit the model.
    task automatic applyStimulus(input logic rst, input logic oready);
        int         win;
        logic       expOv;
        logic       pop;
        logic       grantOk;
        logic [3:0] expReady;
        exp_t       e;
        @(negedge clk);
        clr       = rst;
        out_ready = oready;
        req_valid = hv;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*BA +: BA] = ha[i];
            req_b[i*BB +: BB] = hb[i];
        end
        #1;
        expOv   = (q.size() > 0) && (q[0].cyc <= now - 2);
        pop     = expOv && oready;
        grantOk = (q.size() - int'(pop)) < 2;
        win     = -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (win < 0 && hv[(mPtr + k) % NREQ]) win = (mPtr + k) % NREQ;
        end
        expReady = '0;
        if (grantOk && win >= 0) expReady[win] = 1'b1;
        checkOutput("req_ready", req_ready, expReady);
        checkOutput("out_valid", out_valid, expOv);
        checkOutput("busy", busy, q.size() > 0);
        if (expOv) begin
            checkOutput("out_sum", out_sum, q[0].sum);
            checkOutput("out_id", out_id, 64'(q[0].id));
        end
        obsReady = req_ready;
        if (rst) begin
            q.delete();
            mPtr = NREQ - 1;
        end else begin
            if (pop) void'(q.pop_front());
            if (expReady != 0) begin
                e.sum = ha[win] + hb[win];
                e.id  = win;
                e.cyc = now;
                q.push_back(e);
                mPtr    = win;
                hv[win] = 1'b0;
            end
        end
        now++;
    endtask

    task automatic refillAll();
        for (int i = 0; i < NREQ; i++) begin
            if (!hv[i]) begin
                hv[i] = 1'b1;
                ha[i] = $urandom;
                hb[i] = $urandom;
            end
        end
    endtask

    initial begin
        int nGrants;
        for (int i = 0; i < NREQ; i++) begin
            ha[i] = '0;
            hb[i] = '0;
        end
        clr       = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        clr2      = 1'b1;
        rv2       = '0;
        ra2       = '0;
        rb2       = '0;
        or2       = 1'b1;
        repeat (2) @(posedge clk);
        clr2 = 1'b0;

        $display("[TB] reset state");
        applyStimulus(1'b0, 1'b1);
        checkOutput("rst_sum", out_sum, 0);
        checkOutput("rst_id", out_id, 0);

        $display("[TB] single request");
        hv    = 4'b0001;
        ha[0] = 32'd5;
        hb[0] = 32'hFFFF_FFF9;
        applyStimulus(1'b0, 1'b1);
        checkOutput("single_ready", obsReady, 4'b0001);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("single_valid", out_valid, 1);
        checkOutput("single_sum", out_sum, 32'hFFFF_FFFE);
        checkOutput("single_id", out_id, 0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("single_busy", busy, 0);

        $display("[TB] round robin");
        for (int i = 0; i < 12; i++) begin
            refillAll();
            applyStimulus(1'b0, 1'b1);
            checkOutput("rr_grant", obsReady, 64'(1 << ((i + 1) % NREQ)));
        end
        hv = '0;
        repeat (3) applyStimulus(1'b0, 1'b1);

        $display("[TB] backpressure");
        nGrants = 0;
        for (int i = 0; i < 6; i++) begin
            refillAll();
            applyStimulus(1'b0, 1'b0);
            if (obsReady != 0) nGrants++;
        end
        checkOutput("bp_grants", nGrants, 2);
        checkOutput("bp_valid", out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            refillAll();
            applyStimulus(1'b0, 1'b1);
        end
        hv = '0;
        repeat (4) applyStimulus(1'b0, 1'b1);

        $display("[TB] wrap-around");
        hv    = 4'b0001;
        ha[0] = 32'h7FFF_FFFF;
        hb[0] = 32'd1;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("wrap_sum", out_sum, 32'h8000_0000);
        applyStimulus(1'b0, 1'b1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 4; i++) begin
            refillAll();
            applyStimulus(1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b0);
        refillAll();
        applyStimulus(1'b0, 1'b1);
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_grant", obsReady, 4'b0001);
        hv = '0;
        repeat (4) applyStimulus(1'b0, 1'b1);

        $display("[TB] sparse requests");
        hv = 4'b0010;
        applyStimulus(1'b0, 1'b1);
        hv    = 4'b0100;
        ha[2] = $urandom;
        hb[2] = $urandom;
        applyStimulus(1'b0, 1'b1);
        checkOutput("sparse_skip", obsReady, 4'b0100);
        hv = 4'b1100;
        applyStimulus(1'b0, 1'b1);
        checkOutput("sparse_rr", obsReady, 4'b1000);
        applyStimulus(1'b0, 1'b1);
        checkOutput("sparse_next", obsReady, 4'b0100);
        hv = '0;
        repeat (4) applyStimulus(1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!hv[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        hv[i] = 1'b1;
                        ha[i] = ($urandom_range(7, 0) == 0) ? 32'h8000_0000 : $urandom;
                        hb[i] = $urandom;
                    end
                end else if ($urandom_range(9, 0) == 0) begin
                    hv[i] = 1'b0;
                end
            end
            applyStimulus($urandom_range(99, 0) == 0, $urandom_range(9, 0) < 7);
        end
        hv = '0;
        repeat (5) applyStimulus(1'b0, 1'b1);

        $display("[TB] narrow operand sign extension");
        @(negedge clk);
        rv2 = 2'b01;
        ra2 = {16'h0000, 16'h8000};
        rb2 = {16'h0000, 16'h8000};
        #1;
        checkOutput("w16_ready", ready2, 2'b01);
        @(negedge clk);
        rv2 = 2'b00;
        @(negedge clk);
        #1;
        checkOutput("w16_valid", ov2, 1);
        checkOutput("w16_sum", sum2, 32'hFFFF_0000);
        checkOutput("w16_id", id2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
